// File: rtl/dmem_access_unit.sv
// Data-memory access stage: turns byte/half/word CPU accesses into word-aligned bus cycles
// with byte enables and extends load data. Optional bus timeout is built with DMEM_TIMEOUT_EN.
module dmem_access_unit #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic              cpu_we,
    input  logic              cpu_re,
    input  logic [2:0]        cpu_dmtype,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    output logic              misalign_err,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] DM_WORD = 3'b000;
    localparam logic [2:0] DM_HALF = 3'b001;
    localparam logic [2:0] DM_HALFU = 3'b010;
    localparam logic [2:0] DM_BYTE = 3'b011;
    localparam logic [2:0] DM_BYTEU = 3'b100;

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       cpu_rdata_q, cpu_rdata_d;
    logic [1:0]        off_q, off_d;
    logic [2:0]        dmtype_q, dmtype_d;

    logic              access;
    logic              is_half;
    logic              is_byte;
    logic              misaligned;
    logic [1:0]        off;
    logic [3:0]        be_new;
    logic [31:0]       wdata_new;
    logic [31:0]       rdata_ext;

    // Handshake: mem_req rises with the registered address/data and stays high with all bus
    // outputs frozen until the cycle mem_ready is seen high; mem_ready outside REQ is ignored.

    // Extends the selected lane(s) of a bus word according to the latched access type.
    function automatic logic [31:0] extend_load(input logic [31:0] d, input logic [1:0] a,
                                                input logic [2:0] t);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = d >> {a, 3'b000};
        b  = sh[7:0];
        h  = a[1] ? d[31:16] : d[15:0];
        case (t)
            DM_HALF:  extend_load = {{16{h[15]}}, h};
            DM_HALFU: extend_load = {16'h0000, h};
            DM_BYTE:  extend_load = {{24{b[7]}}, b};
            DM_BYTEU: extend_load = {24'h000000, b};
            default:  extend_load = d;
        endcase
    endfunction

    assign access = cpu_re | cpu_we;
    assign off    = cpu_addr[1:0];

    // Unknown dmtype codes behave as word accesses.
    always_comb begin
        is_half    = (cpu_dmtype == DM_HALF) || (cpu_dmtype == DM_HALFU);
        is_byte    = (cpu_dmtype == DM_BYTE) || (cpu_dmtype == DM_BYTEU);
        misaligned = 1'b0;
        be_new     = 4'b1111;
        wdata_new  = cpu_wdata;
        if (is_byte) begin
            be_new    = 4'b0001 << off;
            wdata_new = {24'h000000, cpu_wdata[7:0]} << {off, 3'b000};
        end else if (is_half) begin
            misaligned = off[0];
            be_new     = 4'b0011 << off;
            wdata_new  = {16'h0000, cpu_wdata[15:0]} << {off, 3'b000};
        end else begin
            misaligned = (off != 2'b00);
        end
    end

    assign rdata_ext = extend_load(mem_rdata, off_q, dmtype_q);

`ifdef DMEM_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             bus_err_q, bus_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        cpu_rdata_d = cpu_rdata_q;
        off_d       = off_q;
        dmtype_d    = dmtype_q;
`ifdef DMEM_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        bus_err_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (access && !misaligned) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = cpu_we;
                    mem_addr_d  = {cpu_addr[ADDR_W-1:2], 2'b00};
                    mem_wdata_d = wdata_new;
                    mem_be_d    = be_new;
                    off_d       = off;
                    dmtype_d    = cpu_dmtype;
                    state_d     = S_REQ;
`ifdef DMEM_TIMEOUT_EN
                    tmo_cnt_d   = '0;
`endif
                end
            end
            S_REQ: begin
                if (mem_ready) begin
                    if (!mem_we_q) begin
                        cpu_rdata_d = rdata_ext;
                    end
                    mem_req_d = 1'b0;
                    state_d   = S_DONE;
`ifdef DMEM_TIMEOUT_EN
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    if (!mem_we_q) begin
                        cpu_rdata_d = 32'h0000_0000;
                    end
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0000_0000;
            mem_be_q    <= 4'b0000;
            cpu_rdata_q <= 32'h0000_0000;
            off_q       <= 2'b00;
            dmtype_q    <= 3'b000;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            cpu_rdata_q <= cpu_rdata_d;
            off_q       <= off_d;
            dmtype_q    <= dmtype_d;
        end
    end

`ifdef DMEM_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            bus_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

    // The pipeline is released in DONE so it advances on the edge that leaves DONE.
    assign cpu_stall    = ((state_q == S_IDLE) && access && !misaligned) || (state_q == S_REQ);
    assign misalign_err = (state_q == S_IDLE) && access && misaligned;

    assign cpu_rdata = cpu_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed plan items plus randomized accesses
// checked against an arithmetic reference model.
module tb_dmem_access_unit;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_we;
    logic              cpu_re;
    logic [2:0]        cpu_dmtype;
    logic [31:0]       cpu_rdata;
    logic              cpu_stall;
    logic              misalign_err;
    logic              bus_err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic [31:0]       mem_rdata;
    logic              mem_ready;
    logic [1:0]        dbg_state;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_rdata;

    dmem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
        .cpu_dmtype(cpu_dmtype), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .misalign_err(misalign_err), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // reference model
    function automatic int nbytes(input logic [2:0] t);
        if (t == 3'd1 || t == 3'd2) return 2;
        if (t == 3'd3 || t == 3'd4) return 1;
        return 4;
    endfunction

    function automatic logic [31:0] ref_be(input logic [2:0] t, input logic [1:0] off);
        int v;
        v = ((1 << nbytes(t)) - 1) << off;
        return 32'(v);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] t, input logic [1:0] off,
                                              input logic [31:0] wd);
        logic [63:0] m;
        m = (64'd1 << (8 * nbytes(t))) - 64'd1;
        return 32'(({32'd0, wd} & m) << (8 * off));
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [2:0] t,
                                             input logic [1:0] off);
        int          n;
        logic [31:0] v;
        n = nbytes(t);
        if (n == 4) return rd;
        v = (rd >> (8 * off)) & ((32'd1 << (8 * n)) - 32'd1);
        if ((t == 3'd1 || t == 3'd3) && v >= (32'd1 << (8 * n - 1)))
            v = v - (32'd1 << (8 * n));
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // driver: one complete aligned access with `waits` REQ cycles of mem_ready low
    task automatic do_access(input logic we, input logic re, input logic [2:0] t,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rd, input int waits);
        int          stall_cnt;
        int          n;
        logic [1:0]  off;
        logic [31:0] exp;
        off = addr[1:0];
        if (!we) exp_q.push_back(ref_load(rd, t, off));
        cpu_we = we; cpu_re = re; cpu_dmtype = t; cpu_addr = addr; cpu_wdata = wd;
        mem_ready = 1'b0; mem_rdata = $urandom;
        #1;
        check("idle_stall", 32'(cpu_stall), 32'd1);
        check("idle_misalign", 32'(misalign_err), 32'd0);
        check("idle_req", 32'(mem_req), 32'd0);
        stall_cnt = 1;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (cpu_stall) stall_cnt++;
            check("req_req", 32'(mem_req), 32'd1);
            check("req_addr", mem_addr, {addr[31:2], 2'b00});
            check("req_be", 32'(mem_be), ref_be(t, off));
            check("req_we", 32'(mem_we), 32'(we));
            if (we) check("req_wdata", mem_wdata, ref_wdata(t, off, wd));
            if (n < waits) begin
                n++;
                mem_ready = 1'b0;
            end else begin
                mem_ready = 1'b1;
                mem_rdata = rd;
                break;
            end
        end
        @(posedge clk); #1;
        check("done_stall", 32'(cpu_stall), 32'd0);
        check("done_req", 32'(mem_req), 32'd0);
        check("done_bus_err", 32'(bus_err), 32'd0);
        if (!we) begin
            exp = exp_q.pop_front();
            model_rdata = exp;
        end
        check("done_rdata", cpu_rdata, model_rdata);
        check("stall_cycles", 32'(stall_cnt), 32'(waits + 2));
        cpu_we = 1'b0; cpu_re = 1'b0; mem_ready = 1'b0; mem_rdata = $urandom;
        @(posedge clk); #1;
        check("idle_after_stall", 32'(cpu_stall), 32'd0);
        check("idle_after_req", 32'(mem_req), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  t;
        int          sel;
        int          req_cycles;
        rst = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_re = 1'b0;
        cpu_dmtype = 3'd0; mem_rdata = '0; mem_ready = 1'b0; model_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_be", 32'(mem_be), 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // byte store at 0x1001
        do_access(1'b1, 1'b0, 3'd3, 32'h0000_1001, 32'hAABB_CCDD, 32'h0, 0);
        // byte loads
        do_access(1'b0, 1'b1, 3'd3, 32'h0000_1003, 32'h0, 32'h8011_2233, 0);
        check("lb_const", cpu_rdata, 32'hFFFF_FF80);
        do_access(1'b0, 1'b1, 3'd4, 32'h0000_1003, 32'h0, 32'h8011_2233, 0);
        check("lbu_const", cpu_rdata, 32'h0000_0080);
        // halfword loads
        do_access(1'b0, 1'b1, 3'd1, 32'h0000_1002, 32'h0, 32'h8001_BEEF, 0);
        check("lh_const", cpu_rdata, 32'hFFFF_8001);
        do_access(1'b0, 1'b1, 3'd2, 32'h0000_1000, 32'h0, 32'h8001_BEEF, 1);
        check("lhu_const", cpu_rdata, 32'h0000_BEEF);
        // word load with 3 wait states
        do_access(1'b0, 1'b1, 3'd0, 32'h0000_2000, 32'h0, 32'h1234_5678, 3);
        // store with both re and we high is a write; cpu_rdata must hold
        do_access(1'b1, 1'b1, 3'd0, 32'h0000_2004, 32'hCAFE_F00D, 32'h0, 2);
        check("write_keeps_rdata", cpu_rdata, 32'h1234_5678);

        // misaligned word load
        cpu_re = 1'b1; cpu_dmtype = 3'd0; cpu_addr = 32'h0000_1002;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("mis_err", 32'(misalign_err), 32'd1);
            check("mis_stall", 32'(cpu_stall), 32'd0);
            check("mis_req", 32'(mem_req), 32'd0);
            @(posedge clk); #1;
        end
        // misaligned halfword load
        cpu_dmtype = 3'd1; cpu_addr = 32'h0000_1001;
        #1;
        check("mis_half_err", 32'(misalign_err), 32'd1);
        @(posedge clk); #1;
        check("mis_half_req", 32'(mem_req), 32'd0);
        cpu_re = 1'b0;

        // stray mem_ready while idle is ignored
        mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        repeat (2) begin
            @(posedge clk); #1;
            check("stray_ready_req", 32'(mem_req), 32'd0);
            check("stray_ready_rdata", cpu_rdata, model_rdata);
        end
        mem_ready = 1'b0;

        // randomized accesses
        for (int k = 0; k < 40; k++) begin
            t = 3'($urandom_range(0, 4));
            a = $urandom & 32'hFFFF_FFFC;
            if (nbytes(t) == 2) a[1] = 1'($urandom_range(0, 1));
            if (nbytes(t) == 1) a[1:0] = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 2);
            do_access(sel != 0, sel != 1, t, a, $urandom, $urandom, $urandom_range(0, 4));
        end

        // reset asserted mid-transfer
        cpu_re = 1'b1; cpu_dmtype = 3'd0; cpu_addr = 32'h0000_3000; mem_ready = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_req", 32'(mem_req), 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'd0);
        check("mid_rst_rdata", cpu_rdata, 32'd0);
        cpu_re = 1'b0;
        model_rdata = 32'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("post_rst_req", 32'(mem_req), 32'd0);
        end

`ifdef DMEM_TIMEOUT_EN
        do_access(1'b0, 1'b1, 3'd0, 32'h0000_4000, 32'h0, 32'h5555_AAAA, 0);
        cpu_re = 1'b1; cpu_dmtype = 3'd0; cpu_addr = 32'h0000_4004; mem_ready = 1'b0;
        req_cycles = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (mem_req) req_cycles++;
            else break;
        end
        check("tmo_req_cycles", 32'(req_cycles), 32'd16);
        check("tmo_bus_err", 32'(bus_err), 32'd1);
        check("tmo_rdata", cpu_rdata, 32'd0);
        check("tmo_stall", 32'(cpu_stall), 32'd0);
        cpu_re = 1'b0;
        model_rdata = 32'd0;
        @(posedge clk); #1;
        check("tmo_bus_err_pulse", 32'(bus_err), 32'd0);
`else
        req_cycles = 0;
        cpu_re = 1'b1; cpu_dmtype = 3'd0; cpu_addr = 32'h0000_4004; mem_ready = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (mem_req) req_cycles++;
        end
        check("no_tmo_req_held", 32'(req_cycles), 32'd20);
        check("no_tmo_bus_err", 32'(bus_err), 32'd0);
        mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        check("late_ready_rdata", cpu_rdata, 32'h0BAD_F00D);
        cpu_re = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
`endif

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
